// File: rtl/sort_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : sort_result_checker
// Purpose  : Verifies a 4-entry sorter result (descending order + permutation)
// Revision : 1.0 - initial release
// ============================================================================
module sort_result_checker #(
    parameter int          W        = 4,
    parameter int          TIMEOUT  = 15,
    parameter logic [2:0]  DONE_VAL = 3'b010
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic [W-1:0] s0,
    input  logic [W-1:0] s1,
    input  logic [W-1:0] s2,
    input  logic [W-1:0] s3,
    input  logic [2:0]   done_in,
    output logic         busy,
    output logic         result_valid,
    output logic         pass,
    output logic [1:0]   err_code,
    output logic [2:0]   led
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ORDER  = 3'd2,
        ST_PERM   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

    state_t       state;
    logic [W-1:0] xc [4];
    logic [W-1:0] sc [4];
    logic [1:0]   idx;
    logic [7:0]   timer;
    logic         armed;

    logic [1:0]   idx_next;
    logic [W-1:0] key;
    logic [2:0]   cx;
    logic [2:0]   cs;
    logic         order_ok;

    assign idx_next = idx + 2'd1;
    assign key      = xc[idx];
    assign order_ok = (sc[idx] >= sc[idx_next]);

    // Multiset equality: every captured operand must occur equally often in both sets
    always_comb begin
        cx = 3'd0;
        cs = 3'd0;
        for (int j = 0; j < 4; j++) begin
            if (xc[j] == key) cx = cx + 3'd1;
            if (sc[j] == key) cs = cs + 3'd1;
        end
    end

    always_comb begin
        led = 3'b000;
        if (busy)                  led = 3'b001;
        else if (pass)             led = 3'b010;
        else if (err_code != 2'b00) led = 3'b100;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            pass         <= 1'b0;
            err_code     <= 2'b00;
            idx          <= 2'd0;
            timer        <= 8'd0;
            armed        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                xc[i] <= '0;
                sc[i] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        xc[0]    <= x0;
                        xc[1]    <= x1;
                        xc[2]    <= x2;
                        xc[3]    <= x3;
                        timer    <= 8'd0;
                        armed    <= 1'b0;
                        pass     <= 1'b0;
                        err_code <= 2'b00;
                        busy     <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timer <= timer + 8'd1;
                    // A done code left over from the previous sort must drop before it counts
                    if (done_in != DONE_VAL) armed <= 1'b1;
                    if (armed && (done_in == DONE_VAL)) begin
                        sc[0] <= s0;
                        sc[1] <= s1;
                        sc[2] <= s2;
                        sc[3] <= s3;
                        idx   <= 2'd0;
                        state <= ST_ORDER;
                    end else if (timer == c_TIMER_LAST) begin
                        err_code     <= 2'b11;
                        result_valid <= 1'b1;
                        state        <= ST_REPORT;
                    end
                end
                ST_ORDER: begin
                    if (!order_ok) begin
                        err_code     <= 2'b01;
                        result_valid <= 1'b1;
                        state        <= ST_REPORT;
                    end else if (idx == 2'd2) begin
                        idx   <= 2'd0;
                        state <= ST_PERM;
                    end else begin
                        idx <= idx_next;
                    end
                end
                ST_PERM: begin
                    if (cx != cs) begin
                        err_code     <= 2'b10;
                        result_valid <= 1'b1;
                        state        <= ST_REPORT;
                    end else if (idx == 2'd3) begin
                        err_code     <= 2'b00;
                        pass         <= 1'b1;
                        result_valid <= 1'b1;
                        state        <= ST_REPORT;
                    end else begin
                        idx <= idx_next;
                    end
                end
                ST_REPORT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
